debounced_input_pio: RTL



---
 rtl/debounced_input_pio.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/debounced_input_pio.sv
// debounced_input_pio
// Avalon-MM input peripheral for push-buttons and slide switches.
// Each raw pin is synchronised (2 flops), debounced by a per-channel
// stability counter, and edge-detected. Captured edges are sticky
// (write-1-to-clear) and drive a maskable level interrupt.
//
// CSR window (word addresses):
//   0 DATA     RO   debounced levels
//   1 IRQMASK  RW   per-bit interrupt enable
//   2 EDGECAP  W1C  sticky captured edges
//   3 EDGEMODE RW   [1:0] 00 rising, 01 falling, 10 both, 11 disabled
module debounced_input_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] in_export,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES; it only ever reaches
    // DEBOUNCE_CYCLES-1 before being cleared, so it can never wrap.
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_ECAP = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    // Synchroniser
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Debounce
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] stable_dly_q;

    // Edge detection
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;

    // CSRs
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [1:0]       edgemode_q;
    logic [1:0]       edgemode_d;
    logic [WIDTH-1:0] w1c_mask;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    // Upper write-data bits beyond the channel count are simply ignored.
    logic wdata_unused;
    assign wdata_unused = ^avs_writedata;

    // Two-flop synchroniser; both stages start at the idle level so the
    // debouncer sees no change coming out of reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= IDLE_VEC;
            sync2_q <= IDLE_VEC;
        end else begin
            sync1_q <= in_export;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: count consecutive disagreeing cycles; accept the
    // new level when the run reaches DEBOUNCE_CYCLES, any agreement restarts.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Debounce state registers plus the one-cycle-delayed stable level used
    // for edge detection (reset to idle so reset never looks like an edge).
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q     <= IDLE_VEC;
            stable_dly_q <= IDLE_VEC;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    assign rise = stable_q & ~stable_dly_q;
    assign fall = ~stable_q & stable_dly_q;

    // Select which debounced edges are captured according to EDGEMODE.
    always_comb begin
        edge_hit = '0;
        case (edgemode_q)
            MODE_RISE: edge_hit = rise;
            MODE_FALL: edge_hit = fall;
            MODE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = '0;
        endcase
    end

    // CSR next-state: writes land on the sampling edge; a new edge wins over
    // a simultaneous write-1-to-clear of the same bit.
    always_comb begin
        irqmask_d  = irqmask_q;
        edgemode_d = edgemode_q;
        w1c_mask   = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_MASK: irqmask_d  = avs_writedata[WIDTH-1:0];
                ADDR_ECAP: w1c_mask   = avs_writedata[WIDTH-1:0];
                ADDR_MODE: edgemode_d = avs_writedata[1:0];
                default:   ;
            endcase
        end
        edgecap_d = (edgecap_q & ~w1c_mask) | edge_hit;
    end

    // Read mux over current register values, so a same-cycle write is not
    // yet visible to the read.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = stable_q;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask_q;
            ADDR_ECAP: rd_mux[WIDTH-1:0] = edgecap_q;
            default:   rd_mux[1:0]       = edgemode_q;
        endcase
        readdata_d = avs_read ? rd_mux : readdata_q;
    end

    // CSR and read-data registers; read data holds until the next read.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            edgemode_q <= MODE_RISE;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            edgemode_q <= edgemode_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = |(edgecap_q & irqmask_q);

endmodule
